// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizing for the RAM port arbiter.
// The FSM encoding lives here so the arbiter and any tooling agree on it.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam int DEF_AW       = 6;
    localparam int DEF_DW       = 8;
    localparam int DEF_LOCK_MAX = 16;

    function automatic arb_state_t lock_state(input logic id);
        return id ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: masked valids, tie goes to the requester
// that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] elig;

    always_comb begin
        elig = valid & mask;
        gnt  = elig;
        if (elig == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port synchronous RAM,
// with lock ownership for read-modify-write and routed read responses.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic          req0_lock,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic          req1_lock,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          lock_timeout
);

    localparam int CW = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          last_q, last_d;
    logic [1:0]    mask, gnt;
    logic          accept, acc_id, sel_we, sel_lock;
    logic [AW-1:0] sel_addr, addr_q;
    logic [DW-1:0] sel_wdata, wdata_q;
    logic          vld_p0, owner_p0;
    logic [1:0]    vld_p1;
    logic [DW-1:0] data0_p1, data1_p1;

    always_comb begin
        case (state_q)
            ST_LOCK0: mask = 2'b01;
            ST_LOCK1: mask = 2'b10;
            default:  mask = 2'b11;
        endcase
    end

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_q),
        .mask       (mask),
        .gnt        (gnt)
    );

    // Readies stay low while reset is asserted, even though it is asynchronous.
    assign req0_ready = gnt[0] & ~rst;
    assign req1_ready = gnt[1] & ~rst;
    assign accept     = req0_ready | req1_ready;
    assign acc_id     = req1_ready;

    assign sel_we    = acc_id ? req1_we    : req0_we;
    assign sel_lock  = acc_id ? req1_lock  : req0_lock;
    assign sel_addr  = acc_id ? req1_addr  : req0_addr;
    assign sel_wdata = acc_id ? req1_wdata : req0_wdata;

    assign ram_we    = accept & sel_we;
    assign ram_addr  = accept ? sel_addr  : addr_q;
    assign ram_wdata = accept ? sel_wdata : wdata_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        lock_timeout = 1'b0;
        if (accept) begin
            last_d = acc_id;
        end
        case (state_q)
            ST_OPEN: begin
                if (accept && sel_lock) begin
                    state_d = lock_state(acc_id);
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                // An owner unlocking on the last allowed cycle is a normal release.
                if (accept && !sel_lock) begin
                    state_d = ST_OPEN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_OPEN;
                    lock_timeout = 1'b1;
                    last_d       = (state_q == ST_LOCK1);
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OPEN;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= (state_q == ST_OPEN) ? '0 : cnt_q + 1'b1;
            if (accept) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // p0: read accepted, RAM samples the address; p1: RAM data captured per owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            owner_p0 <= 1'b0;
            vld_p1   <= 2'b00;
            data0_p1 <= '0;
            data1_p1 <= '0;
        end else begin
            vld_p0 <= accept & ~sel_we;
            if (accept) begin
                owner_p0 <= acc_id;
            end
            vld_p1 <= {vld_p0 & owner_p0, vld_p0 & ~owner_p0};
            if (vld_p0 && !owner_p0) begin
                data0_p1 <= ram_rdata;
            end
            if (vld_p0 && owner_p0) begin
                data1_p1 <= ram_rdata;
            end
        end
    end

    assign rsp0_valid = vld_p1[0];
    assign rsp1_valid = vld_p1[1];
    assign rsp0_data  = data0_p1;
    assign rsp1_data  = data1_p1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand-written reset
// sequences and random traffic, all checked against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LM = 4;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req0_we, req0_lock;
    logic req1_valid, req1_ready, req1_we, req1_lock;
    logic [AW-1:0] req0_addr, req1_addr, ram_addr;
    logic [DW-1:0] req0_wdata, req1_wdata, ram_wdata, ram_rdata;
    logic rsp0_valid, rsp1_valid, ram_we, lock_timeout;
    logic [DW-1:0] rsp0_data, rsp1_data;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .lock_timeout(lock_timeout)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 1);
    endfunction

    // Behavioural 64x8 synchronous RAM, write-through on a same-address write.
    logic [DW-1:0] ram_mem [64];
    logic ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= pat(i);
            ram_init_done <= 1'b1;
        end else begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_we ? ram_wdata : ram_mem[ram_addr];
        end
    end

    typedef struct {
        logic v0, we0, lk0; logic [5:0] a0; logic [7:0] d0;
        logic v1, we1, lk1; logic [5:0] a1; logic [7:0] d1;
        logic e_r0, e_r1, e_rv0, e_rv1, e_tmo; logic [7:0] e_rd;
    } vec_t;

    typedef struct { int who; logic [7:0] data; int due; } rsp_t;

    function automatic vec_t V(input logic v0, we0, lk0, input logic [5:0] a0, input logic [7:0] d0,
                               input logic v1, we1, lk1, input logic [5:0] a1, input logic [7:0] d1,
                               input logic r0, r1, rv0, rv1, tmo, input logic [7:0] rd);
        vec_t x;
        x.v0 = v0; x.we0 = we0; x.lk0 = lk0; x.a0 = a0; x.d0 = d0;
        x.v1 = v1; x.we1 = we1; x.lk1 = lk1; x.a1 = a1; x.d1 = d1;
        x.e_r0 = r0; x.e_r1 = r1; x.e_rv0 = rv0; x.e_rv1 = rv1; x.e_tmo = tmo; x.e_rd = rd;
        return x;
    endfunction

    // Transaction-level model: lock owner (-1 = none), cycles held, last winner.
    logic [7:0] mmem [64];
    int m_owner, m_age, m_last;
    logic [7:0] m_rsp0, m_rsp1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    rsp_t rq[$];
    int cyc, n_cmp, n_bad;
    logic s_r0, s_r1, s_rv0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_last = 1;
        m_rsp0 = '0; m_rsp1 = '0; m_addr = '0; m_wdata = '0;
        rq.delete();
    endtask

    task automatic do_cycle(input vec_t v, input logic r, input bit use_exp);
        int g;
        bit tmo, own_unlock, gsel, gwe, glk, erv0, erv1;
        logic [5:0] ga, eaddr;
        logic [7:0] gd, ewd;
        req0_valid = v.v0; req0_we = v.we0; req0_lock = v.lk0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_we = v.we1; req1_lock = v.lk1; req1_addr = v.a1; req1_wdata = v.d1;
        rst = r;
        @(negedge clk);
        if (r) model_reset();
        g = -1; tmo = 0; own_unlock = 0;
        if (!r) begin
            if (m_owner == 0)      g = v.v0 ? 0 : -1;
            else if (m_owner == 1) g = v.v1 ? 1 : -1;
            else if (v.v0 && v.v1) g = (m_last == 1) ? 0 : 1;
            else if (v.v0)         g = 0;
            else if (v.v1)         g = 1;
            own_unlock = (m_owner >= 0) && (g == m_owner) && !((m_owner == 1) ? v.lk1 : v.lk0);
            tmo = (m_owner >= 0) && (m_age == LM - 1) && !own_unlock;
        end
        gsel = (g == 1);
        gwe = gsel ? v.we1 : v.we0;
        glk = gsel ? v.lk1 : v.lk0;
        ga  = gsel ? v.a1 : v.a0;
        gd  = gsel ? v.d1 : v.d0;
        eaddr = (g >= 0) ? ga : m_addr;
        ewd   = (g >= 0) ? gd : m_wdata;
        chk("rdy0", 32'(req0_ready), 32'(g == 0));
        chk("rdy1", 32'(req1_ready), 32'(g == 1));
        chk("lock_timeout", 32'(lock_timeout), 32'(tmo));
        chk("ram_we", 32'(ram_we), 32'((g >= 0) && gwe));
        chk("ram_addr", 32'(ram_addr), 32'(eaddr));
        chk("ram_wdata", 32'(ram_wdata), 32'(ewd));
        erv0 = 0; erv1 = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].who == 1) begin erv1 = 1; m_rsp1 = rq[0].data; end
            else begin erv0 = 1; m_rsp0 = rq[0].data; end
            void'(rq.pop_front());
        end
        chk("rsp0_valid", 32'(rsp0_valid), 32'(erv0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(erv1));
        chk("rsp0_data", 32'(rsp0_data), 32'(m_rsp0));
        chk("rsp1_data", 32'(rsp1_data), 32'(m_rsp1));
        if (use_exp) begin
            chk("t_rdy0", 32'(req0_ready), 32'(v.e_r0));
            chk("t_rdy1", 32'(req1_ready), 32'(v.e_r1));
            chk("t_rv0", 32'(rsp0_valid), 32'(v.e_rv0));
            chk("t_rv1", 32'(rsp1_valid), 32'(v.e_rv1));
            chk("t_tmo", 32'(lock_timeout), 32'(v.e_tmo));
            if (v.e_rv0) chk("t_rd0", 32'(rsp0_data), 32'(v.e_rd));
            if (v.e_rv1) chk("t_rd1", 32'(rsp1_data), 32'(v.e_rd));
        end
        s_r0 = req0_ready; s_r1 = req1_ready; s_rv0 = rsp0_valid;
        if (!r) begin
            if (g >= 0) begin
                m_last = g; m_addr = ga; m_wdata = gd;
                if (gwe) mmem[ga] = gd;
                else rq.push_back('{g, mmem[ga], cyc + 2});
            end
            if (m_owner >= 0) begin
                if (own_unlock) m_owner = -1;
                else if (tmo) begin m_last = m_owner; m_owner = -1; end
                else m_age++;
            end else if (g >= 0 && glk) begin
                m_owner = g; m_age = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t idle, rv;
    int g0cnt, g1cnt, pulses;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        for (int i = 0; i < 64; i++) mmem[i] = pat(i);
        model_reset();
        idle = V(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
        rst = 1'b1;
        req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with both requesters valid: nothing may be granted.
        for (int i = 0; i < 3; i++)
            do_cycle(V(1,0,0,3,0, 1,0,0,5,0, 0,0,0,0,0,0), 1'b1, 1'b1);

        tbl.push_back(V(1,0,0,3,0,      1,0,0,5,0,      1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      1,0,0,5,0,      0,1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,1,0,0,8'h16));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,0,1,0,8'h24));
        tbl.push_back(V(1,1,0,10,8'hA5, 0,0,0,0,0,      1,0,0,0,0,0));
        tbl.push_back(V(1,0,0,10,0,     0,0,0,0,0,      1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,1,0,0,8'hA5));
        for (int k = 0; k < 8; k++)
            tbl.push_back(V(1,1,0,20,8'h11, 1,1,0,21,8'h22, 1'(k % 2), 1'((k + 1) % 2),0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      1,1,0,30,8'h33, 0,1,0,0,0,0));
        tbl.push_back(V(1,0,1,7,0,      1,1,0,30,8'h33, 1,0,0,0,0,0));
        tbl.push_back(V(1,1,0,7,8'h77,  1,1,0,30,8'h33, 1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      1,1,0,30,8'h33, 0,1,1,0,0,8'h32));
        tbl.push_back(V(1,1,1,40,8'h44, 0,0,0,0,0,      1,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(V(0,0,0,0,0,  1,1,0,41,8'h41, 0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      1,1,0,41,8'h41, 0,0,0,0,1,0));
        tbl.push_back(V(1,1,0,42,8'h55, 1,1,0,41,8'h41, 0,1,0,0,0,0));
        tbl.push_back(V(1,1,0,42,8'h55, 1,1,0,41,8'h41, 1,0,0,0,0,0));
        tbl.push_back(V(1,0,0,10,0,     1,0,0,7,0,      0,1,0,0,0,0));
        tbl.push_back(V(1,0,0,10,0,     1,0,0,7,0,      1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,0,1,0,8'h77));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,1,0,0,8'hA5));
        tbl.push_back(V(0,0,0,0,0,      1,1,1,50,8'h5A, 0,1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,0,0,0,0));
        tbl.push_back(V(1,1,0,51,8'h66, 0,0,0,0,0,      0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      0,0,0,0,0,      0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,      1,1,0,50,8'h5B, 0,1,0,0,0,0));
        tbl.push_back(V(1,1,0,51,8'h66, 0,0,0,0,0,      1,0,0,0,0,0));

        g0cnt = 0; g1cnt = 0;
        foreach (tbl[i]) begin
            do_cycle(tbl[i], 1'b0, 1'b1);
            if (i >= 8 && i < 16) begin
                g0cnt += int'(s_r0);
                g1cnt += int'(s_r1);
            end
        end
        chk("fair_grants0", 32'(g0cnt), 32'd4);
        chk("fair_grants1", 32'(g1cnt), 32'd4);

        for (int i = 0; i < 600; i++) begin
            rv = idle;
            rv.v0 = ($urandom_range(0, 3) != 0); rv.we0 = 1'($urandom_range(0, 1));
            rv.lk0 = ($urandom_range(0, 4) == 0); rv.a0 = 6'($urandom_range(0, 7)); rv.d0 = 8'($urandom);
            rv.v1 = ($urandom_range(0, 3) != 0); rv.we1 = 1'($urandom_range(0, 1));
            rv.lk1 = ($urandom_range(0, 4) == 0); rv.a1 = 6'($urandom_range(0, 7)); rv.d1 = 8'($urandom);
            do_cycle(rv, 1'b0, 1'b0);
        end

        // Reset the cycle after a read is accepted: its response must never appear.
        do_cycle(idle, 1'b1, 1'b0);
        do_cycle(idle, 1'b0, 1'b0);
        do_cycle(V(1,0,0,3,0, 0,0,0,0,0, 1,0,0,0,0,0), 1'b0, 1'b1);
        do_cycle(idle, 1'b1, 1'b0);
        pulses = int'(s_rv0);
        for (int i = 0; i < 6; i++) begin
            do_cycle(idle, 1'b0, 1'b0);
            pulses += int'(s_rv0);
        end
        chk("mid_reset_rsp0_pulses", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the 64x8 single-port synchronous RAM. It accepts read/write requests over valid/ready handshakes, grants one per cycle round-robin, and drives the RAM's address, write-enable and write-data pins. Read data is routed back to the requester that issued the read. A lock mechanism with a hard timeout gives a requester uninterrupted ownership for read-modify-write sequences.

## Interface
- AW, 6, address width (RAM depth 2^AW)
- DW, 8, data width
- LOCK_MAX, 16, max consecutive cycles a lock may be held before forced release (>=2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- reqN_valid  in  1  request N valid (N = 0,1)
- reqN_ready  out  1  request N accepted this cycle when valid & ready
- reqN_we  in  1  1 = write, 0 = read
- reqN_lock  in  1  keep ownership after this transfer
- reqN_addr  in  AW  address
- reqN_wdata  in  DW  write data
- rspN_valid  out  1  one-cycle pulse: read data for requester N
- rspN_data  out  DW  read data; qualified by rspN_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  drives both RAM read_addr and write_addr
- ram_wdata  out  DW  RAM data_in
- ram_rdata  in  DW  RAM data_out (registered in RAM, 1-cycle latency)
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- Exactly one transfer per cycle at most; reqN_ready is combinational from state and valids; at most one ready high per cycle.
- FSM states: OPEN, LOCK0, LOCK1.
- OPEN: if only one valid, grant it; if both, grant the requester not granted last (last_grant register, reset value 1, so requester 0 wins the first tie). last_grant updates on every accepted transfer.
- Accepted transfer with reqN_lock=1 in OPEN -> LOCKN. In LOCKN only requester N may be granted (other ready forced 0, even if N idle). Accepted transfer from N with lock=0 -> OPEN after that cycle.
- Lock counter: cleared on entering LOCKN, increments each cycle in LOCKN; when it reaches LOCK_MAX-1 the FSM returns to OPEN next cycle, lock_timeout pulses for that one cycle, and last_grant is set to N (other requester gets priority).
- RAM drive on accept: ram_addr = reqN_addr, ram_we = reqN_we, ram_wdata = reqN_wdata. No accept: ram_we=0, ram_addr/ram_wdata hold previous value.
- Reads: response routed via a 1-bit owner register plus pending bit. Writes produce no response.
- No response backpressure: requesters must always accept rspN_valid.
- RAM write-through: a write and a later read to the same address in consecutive cycles returns the new data; because ram_addr drives both RAM addresses, a write's own ram_rdata is the written value but is not forwarded.

## Timing
- Reset values: all reqN_ready=0, rspN_valid=0, rspN_data=0, ram_we=0, ram_addr=0, ram_wdata=0, lock_timeout=0; state OPEN, counter 0, last_grant 1, pending 0.
- Read accepted at edge k -> RAM samples at edge k -> rspN_valid/rspN_data high in cycle after edge k+1 (2-cycle request-to-response, fully pipelined, back-to-back reads give back-to-back responses).
- rspN_data is ram_rdata registered; held between pulses.
- Async rst mid-operation: pending response discarded, lock dropped, no rsp pulse after reset release.
- Forced release and requester's own unlock in the same cycle: treat as normal unlock, no lock_timeout pulse.

## Structure
- Shared package: state encoding (OPEN/LOCK0/LOCK1), default AW/DW/LOCK_MAX constants.
- One natural sub-module: rr_arb2 (2-way round-robin grant from valids + last_grant + mask).
- RAM instanced outside this block; top level wires ram_* to it.

## Test plan
- Reset: hold rst, drive both valids -> all readies 0, rsp 0; after release, both valid reads to addr 3/5 -> req0 granted first, req1 next cycle, rsp0 then rsp1 on consecutive cycles.
- Write/read: req0 writes 0xA5 to addr 10, next cycle reads addr 10 -> rsp0_data=0xA5 two cycles after the read accept; rsp1_valid never asserted.
- Fairness: both requesters continuously valid for 8 cycles -> grants alternate 0,1,0,1...; each gets exactly 4.
- Lock RMW: req0 read addr 7 lock=1, then write addr 7 lock=0 while req1 valid throughout -> req1_ready=0 for both cycles, granted the following cycle.
- Timeout: LOCK_MAX=4, req0 locks and goes idle -> lock_timeout pulses at lock cycle 4, req1 granted next cycle, then req1 preferred over req0 on tie.
- Reset mid-read: assert rst the cycle after a read accept -> no rsp0_valid pulse at any time after.
